wash_phase_timer: RTL and testbench

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

---
 rtl/wash_phase_timer.sv | 196 +++++++++++++++++++
 tb/tb_wash_phase_timer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// ---------------------------------------------------------------------------
// wash_phase_timer
//
// Phase timer for a washing-machine cycle controller. The controller's actuator
// outputs are decoded into the current wash phase. Each time a phase starts, or
// the controller pulses restart, the timer reloads that phase's duration and
// counts it down in prescaled ticks. When the duration runs out, the timer
// raises that phase's expiry flag and holds it until the next load. trinse marks
// the rinse pass: it is the part of the cycle between the first wash expiry and
// the spin expiry.
//
// Optional feature (compile-time macro DOOR_PAUSE_EN):
//   When the macro is defined, an open door pauses an active count. The count
//   resumes with its values intact when the door closes. When the macro is not
//   defined, door is ignored and no pause logic is built.
//
// Parameters:
//   PRESCALE     clocks per timer tick (1..65535)
//   CNT_W        width of the tick counter
//   FILL_TICKS, WASH_TICKS, DRAIN_TICKS, SPIN_TICKS   phase durations in ticks
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   restart      reload the timer for the current phase
//   water_fill, agitator, motor, pump, speed   controller outputs (phase decode)
//   door         door-open indication (used only with DOOR_PAUSE_EN)
//   tfill, twash, tdrain, tspin   registered phase-expired flags
//   trinse       registered rinse-pass indicator
//   busy         timer counting or paused
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wash_phase_timer #(
   parameter int PRESCALE    = 1000,
   parameter int CNT_W       = 16,
   parameter int FILL_TICKS  = 60,
   parameter int WASH_TICKS  = 300,
   parameter int DRAIN_TICKS = 60,
   parameter int SPIN_TICKS  = 120
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic water_fill,
   input  logic agitator,
   input  logic motor,
   input  logic pump,
   input  logic speed,
   input  logic door,
   output logic tfill,
   output logic twash,
   output logic tdrain,
   output logic tspin,
   output logic trinse,
   output logic busy
);

   typedef enum logic [2:0] {PH_NONE, PH_FILL, PH_WASH, PH_DRAIN, PH_SPIN} phase_t;
   typedef enum logic [1:0] {IDLE, COUNT, PAUSE, DONE} state_t;

   localparam logic [15:0]      PRESC_LAST = 16'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_TICKS);
   localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_TICKS);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TICKS);
   localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_TICKS);

   state_t           state;
   phase_t           phase_now;
   phase_t           phase_q;
   phase_t           run_phase;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] load_ticks;
   logic [15:0]      presc;
   logic             load;
   logic             tick;
   logic             expire;
   logic             run_step;

   // Decode the controller outputs into one phase. The checks go from the
   // strongest actuator combination down, because spin also drives motor and a
   // drain can overlap with leftover wash outputs.
   always_comb begin
      phase_now = PH_NONE;
      if (motor && speed)
         phase_now = PH_SPIN;
      else if (pump)
         phase_now = PH_DRAIN;
      else if (agitator && motor)
         phase_now = PH_WASH;
      else if (water_fill)
         phase_now = PH_FILL;
   end

   // Look up the duration for the phase being loaded.
   always_comb begin
      load_ticks = '0;
      case (phase_now)
         PH_FILL:  load_ticks = FILL_LOAD;
         PH_WASH:  load_ticks = WASH_LOAD;
         PH_DRAIN: load_ticks = DRAIN_LOAD;
         PH_SPIN:  load_ticks = SPIN_LOAD;
         default:  load_ticks = '0;
      endcase
   end

   assign load = restart || (phase_now != phase_q);
   assign tick = (presc == PRESC_LAST);

   // A zero counter means a zero-length phase, which expires on the first
   // counting clock. Otherwise the phase expires on the tick that would take
   // the counter from 1 to 0, so the counter never needs to go below zero.
   assign expire = (counter == '0) || (tick && (counter == CNT_W'(1)));

`ifdef DOOR_PAUSE_EN
   // Counting advances only while the door is closed. A paused count resumes
   // on the same edge that sees the door closed, so the pause costs exactly
   // as many clocks as the door was open.
   assign run_step = ((state == COUNT) || (state == PAUSE)) && !door;
   assign busy     = (state == COUNT) || (state == PAUSE);
`else
   logic door_unused;
   assign door_unused = door;
   assign run_step    = (state == COUNT);
   assign busy        = (state == COUNT);
`endif

   // Main timer FSM. A load event takes priority over everything else, which
   // also discards any tick that lands on the same edge. The expiry flags and
   // trinse are updated here so that they are registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         counter   <= '0;
         presc     <= '0;
         phase_q   <= PH_NONE;
         run_phase <= PH_NONE;
         tfill     <= 1'b0;
         twash     <= 1'b0;
         tdrain    <= 1'b0;
         tspin     <= 1'b0;
         trinse    <= 1'b0;
      end else begin
         phase_q <= phase_now;
         if (load) begin
            tfill  <= 1'b0;
            twash  <= 1'b0;
            tdrain <= 1'b0;
            tspin  <= 1'b0;
            presc  <= '0;
            if (phase_now != PH_NONE) begin
               counter   <= load_ticks;
               run_phase <= phase_now;
               state     <= COUNT;
            end else begin
               counter   <= '0;
               run_phase <= PH_NONE;
               state     <= IDLE;
            end
         end else if (run_step) begin
            if (expire) begin
               state   <= DONE;
               counter <= '0;
               presc   <= '0;
               case (run_phase)
                  PH_FILL:  tfill <= 1'b1;
                  PH_WASH: begin
                     twash  <= 1'b1;
                     trinse <= 1'b1;
                  end
                  PH_DRAIN: tdrain <= 1'b1;
                  PH_SPIN: begin
                     tspin  <= 1'b1;
                     trinse <= 1'b0;
                  end
                  default: ;
               endcase
            end else begin
               state <= COUNT;
               if (tick) begin
                  presc   <= '0;
                  counter <= counter - CNT_W'(1);
               end else begin
                  presc <= presc + 16'd1;
               end
            end
         end
`ifdef DOOR_PAUSE_EN
         else if (state == COUNT) begin
            state <= PAUSE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_wash_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_wash_phase_timer
//
// Self-checking bench for wash_phase_timer. A reference model predicts every
// output on every clock. It tracks the active phase and the absolute cycle at
// which that phase must expire, and it moves that deadline out by one cycle
// for each clock the door holds the count (only when DOOR_PAUSE_EN is
// defined). Directed sections measure the expiry latencies. A randomized
// section then drives arbitrary controller outputs, restarts and door
// activity.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wash_phase_timer;

   localparam int PRESCALE = 4;
   localparam int CNT_W    = 8;
   localparam int FILL_T   = 3;
   localparam int WASH_T   = 7;
   localparam int DRAIN_T  = 0;
   localparam int SPIN_T   = 5;

`ifdef DOOR_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   localparam int P_NONE  = 0;
   localparam int P_FILL  = 1;
   localparam int P_WASH  = 2;
   localparam int P_DRAIN = 3;
   localparam int P_SPIN  = 4;

   logic clk;
   logic rst;
   logic restart;
   logic water_fill;
   logic agitator;
   logic motor;
   logic pump;
   logic speed;
   logic door;
   logic tfill;
   logic twash;
   logic tdrain;
   logic tspin;
   logic trinse;
   logic busy;

   wash_phase_timer #(
      .PRESCALE(PRESCALE),
      .CNT_W(CNT_W),
      .FILL_TICKS(FILL_T),
      .WASH_TICKS(WASH_T),
      .DRAIN_TICKS(DRAIN_T),
      .SPIN_TICKS(SPIN_T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .restart(restart),
      .water_fill(water_fill),
      .agitator(agitator),
      .motor(motor),
      .pump(pump),
      .speed(speed),
      .door(door),
      .tfill(tfill),
      .twash(twash),
      .tdrain(tdrain),
      .tspin(tspin),
      .trinse(trinse),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state.
   int         m_prev;
   int         m_run;
   bit         m_active;
   bit         m_expired;
   bit         m_trinse;
   logic [3:0] m_flags;
   longint     m_deadline;

   function automatic int decode(logic wf, logic ag, logic mo, logic pu, logic sp);
      if (mo && sp) return P_SPIN;
      if (pu) return P_DRAIN;
      if (ag && mo) return P_WASH;
      if (wf) return P_FILL;
      return P_NONE;
   endfunction

   function automatic int ticks_of(int ph);
      case (ph)
         P_FILL:  return FILL_T;
         P_WASH:  return WASH_T;
         P_DRAIN: return DRAIN_T;
         P_SPIN:  return SPIN_T;
         default: return 0;
      endcase
   endfunction

   function automatic logic dut_flag(int ph);
      case (ph)
         P_FILL:  return tfill;
         P_WASH:  return twash;
         P_DRAIN: return tdrain;
         P_SPIN:  return tspin;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_prev    = P_NONE;
      m_run     = P_NONE;
      m_active  = 1'b0;
      m_expired = 1'b0;
      m_trinse  = 1'b0;
      m_flags   = 4'b0000;
   endtask

   // Advance the model by one rising edge using the inputs the DUT samples.
   task automatic model_edge();
      int ph;
      int t;
      bit ld;
      cyc++;
      if (rst) begin
         model_reset();
         return;
      end
      ph     = decode(water_fill, agitator, motor, pump, speed);
      ld     = restart || (ph != m_prev);
      m_prev = ph;
      if (ld) begin
         m_flags   = 4'b0000;
         m_expired = 1'b0;
         if (ph != P_NONE) begin
            t          = ticks_of(ph);
            m_active   = 1'b1;
            m_run      = ph;
            m_deadline = longint'(cyc) + ((t == 0) ? 1 : t * PRESCALE);
         end else begin
            m_active = 1'b0;
            m_run    = P_NONE;
         end
      end else if (m_active && !m_expired) begin
         if (PAUSE_ON && door) begin
            m_deadline = m_deadline + 1;
         end else if (longint'(cyc) == m_deadline) begin
            m_expired          = 1'b1;
            m_flags[m_run - 1] = 1'b1;
            if (m_run == P_WASH) m_trinse = 1'b1;
            if (m_run == P_SPIN) m_trinse = 1'b0;
         end
      end
   endtask

   task automatic check_bit(string tag, logic obs, logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s at cycle %0d: observed %0b, expected %0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_output();
      check_bit("tfill", tfill, m_flags[0]);
      check_bit("twash", twash, m_flags[1]);
      check_bit("tdrain", tdrain, m_flags[2]);
      check_bit("tspin", tspin, m_flags[3]);
      check_bit("busy", busy, m_active && !m_expired);
      check_bit("trinse", trinse, m_trinse);
      check_bit("one_flag", ($countones({tspin, tdrain, twash, tfill}) <= 1), 1'b1);
   endtask

   // One clock: let the edge happen, update the model, check just after it.
   task automatic apply_stimulus();
      @(posedge clk);
      model_edge();
      #1;
      check_output();
   endtask

   task automatic set_phase(int ph);
      water_fill = (ph == P_FILL);
      agitator   = (ph == P_WASH);
      motor      = (ph == P_WASH) || (ph == P_SPIN);
      pump       = (ph == P_DRAIN);
      speed      = (ph == P_SPIN);
   endtask

   // Clock until the DUT raises the flag for ph, returning edges taken.
   task automatic wait_flag(int ph, int budget, output int n);
      n = 0;
      do begin
         apply_stimulus();
         n++;
      end while ((dut_flag(ph) !== 1'b1) && (n < budget));
      if (dut_flag(ph) !== 1'b1)
         $display("[TB] wait for phase %0d flag ran out of budget", ph);
   endtask

   initial begin
      int n;
      int hold;
      int seq[7]      = '{P_FILL, P_WASH, P_DRAIN, P_FILL, P_WASH, P_DRAIN, P_SPIN};
      int lat[7]      = '{12, 28, 1, 12, 28, 1, 20};
      bit rinse_of[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst     = 1'b1;
      restart = 1'b0;
      door    = 1'b0;
      set_phase(P_NONE);
      model_reset();

      $display("[TB] reset state");
      apply_stimulus();
      apply_stimulus();
      rst = 1'b0;
      apply_stimulus();
      apply_stimulus();

      $display("[TB] fill latency from idle");
      set_phase(P_FILL);
      apply_stimulus();
      wait_flag(P_FILL, 40, n);
      check_int("fill_latency", n, 12);
      check_bit("busy_at_tfill", busy, 1'b0);
      repeat (3) apply_stimulus();

      $display("[TB] full wash cycle with restarts");
      for (int i = 0; i < 7; i++) begin
         set_phase(seq[i]);
         restart = 1'b1;
         apply_stimulus();
         restart = 1'b0;
         wait_flag(seq[i], 100, n);
         check_int("seq_latency", n, lat[i]);
         check_bit("seq_trinse", trinse, rinse_of[i]);
         repeat (2) apply_stimulus();
      end

      $display("[TB] restart in the middle of wash");
      set_phase(P_WASH);
      restart = 1'b1;
      apply_stimulus();
      restart = 1'b0;
      repeat (8) apply_stimulus();
      restart = 1'b1;
      apply_stimulus();
      restart = 1'b0;
      check_bit("twash_after_restart", twash, 1'b0);
      wait_flag(P_WASH, 100, n);
      check_int("restart_latency", n, 28);

      $display("[TB] phase change on a tick edge into a zero-length phase");
      restart = 1'b1;
      apply_stimulus();
      restart = 1'b0;
      repeat (3) apply_stimulus();
      set_phase(P_DRAIN);
      apply_stimulus();
      wait_flag(P_DRAIN, 10, n);
      check_int("tick_edge_load", n, 1);

      $display("[TB] door open during spin");
      set_phase(P_SPIN);
      restart = 1'b1;
      apply_stimulus();
      restart = 1'b0;
      repeat (3) apply_stimulus();
      door = 1'b1;
      repeat (10) apply_stimulus();
      door = 1'b0;
      wait_flag(P_SPIN, 60, n);
      check_int("door_delay", 13 + n, PAUSE_ON ? 30 : 20);

      $display("[TB] asynchronous reset mid-wash");
      set_phase(P_WASH);
      restart = 1'b1;
      apply_stimulus();
      restart = 1'b0;
      repeat (5) apply_stimulus();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_output();
      check_bit("busy_async_rst", busy, 1'b0);
      apply_stimulus();
      apply_stimulus();
      set_phase(P_NONE);
      rst = 1'b0;
      repeat (5) apply_stimulus();

      $display("[TB] asynchronous reset mid-drain");
      set_phase(P_DRAIN);
      apply_stimulus();
      apply_stimulus();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_output();
      check_bit("tdrain_async_rst", tdrain, 1'b0);
      apply_stimulus();
      rst = 1'b0;
      repeat (4) apply_stimulus();

      $display("[TB] randomized controller activity");
      for (int s = 0; s < 60; s++) begin
         {water_fill, agitator, motor, pump, speed} = 5'($urandom_range(0, 31));
         restart = ($urandom_range(0, 2) == 0);
         hold    = $urandom_range(1, 32);
         for (int k = 0; k < hold; k++) begin
            apply_stimulus();
            restart = ($urandom_range(0, 15) == 0);
            door    = ($urandom_range(0, 3) == 0);
         end
      end
      restart = 1'b0;
      door    = 1'b0;
      repeat (4) apply_stimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
